csa_mult_seq_ctrl: RTL

Iterative unsigned multiplier controller. It sequences a single carry-save reduction row over WIDTH cycles to multiply two operands, then resolves sum/carry with one carry-propagate add. It is the low-area sequential alternative to the fully unrolled CSA multiplier tree. Valid/ready on both input and output sides.

---
 rtl/mult_pkg.sv | 18 +
 rtl/csa_row.sv | 22 ++
 rtl/fulladder.sv | 13 +
 rtl/csa_mult_seq_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential carry-save multiplier.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // One extra bit so the counter can hold WIDTH itself.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/csa_row.sv
// N-bit 3:2 compressor row; carry output is returned unshifted.
module csa_row #(
    parameter int N = 16
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] z,
    output logic [N-1:0] s,
    output logic [N-1:0] c
);

    for (genvar i = 0; i < N; i++) begin : g_fa
        fulladder u_fa (
            .a    (x[i]),
            .b    (y[i]),
            .cin  (z[i]),
            .s    (s[i]),
            .cout (c[i])
        );
    end

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/csa_mult_seq_ctrl.sv
// Iterative unsigned multiplier: one CSA row reused per multiplier bit,
// then a single carry-propagate add, with valid/ready on both sides.
module csa_mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int EARLY_EXIT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_w(WIDTH);

    state_t         state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, b_shift;
    logic [PW-1:0]  sum, carry, pp, s, c;
    logic [CW-1:0]  count, count_inc;
    logic           b_bit, last_bit;

    assign count_inc = count + CW'(1);
    assign b_shift   = b_reg >> count;
    assign b_bit     = b_shift[0];
    assign pp        = b_bit ? ({{WIDTH{1'b0}}, a_reg} << count) : '0;

    // Early exit looks at the bits still to be processed after this edge.
    assign last_bit = (count == CW'(WIDTH - 1)) ||
                      ((EARLY_EXIT != 0) && ((b_reg >> count_inc) == '0));

    csa_row #(.N(PW)) u_row (
        .x (sum),
        .y (carry),
        .z (pp),
        .s (s),
        .c (c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // abort wins over every other transition, but only while work is in flight.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ACCUM;
            end
            ACCUM: begin
                busy = 1'b1;
                if (abort)         state_nxt = IDLE;
                else if (last_bit) state_nxt = RESOLVE;
            end
            RESOLVE: begin
                busy = 1'b1;
                if (abort) state_nxt = IDLE;
                else       state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum     <= '0;
            carry   <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        sum   <= '0;
                        carry <= '0;
                        count <= '0;
                    end
                end
                ACCUM: begin
                    if (!abort) begin
                        sum   <= s;
                        carry <= c << 1;
                        count <= count_inc;
                    end
                end
                RESOLVE: begin
                    if (!abort) product <= sum + carry;
                end
                default: ;
            endcase
        end
    end

endmodule
